// File: rtl/gpr_writeback.sv
// Register-file write-side driver: buffers writeback requests, aligns MIPS loads, issues one write per cycle.
// Define GPR_WB_UNALIGNED_EN to enable LWL/LWR alignment; otherwise ops 5/6 behave as WORD.
module gpr_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [2:0]                req_op,
    input  logic [1:0]                req_offset,
    output logic                      gpr_write,
    output logic [ADDR_WIDTH-1:0]     gpr_rd_addr,
    output logic [DATA_WIDTH-1:0]     gpr_rd_in,
    output logic [3:0]                gpr_byte_w_en,
    output logic [2**ADDR_WIDTH-1:0]  pending_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_WORD = 3'd0,
        OP_LB   = 3'd1,
        OP_LBU  = 3'd2,
        OP_LH   = 3'd3,
        OP_LHU  = 3'd4,
        OP_LWL  = 3'd5,
        OP_LWR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            en;
    } entry_t;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("gpr_writeback: byte-lane logic supports DATA_WIDTH == 32 only");
    end
    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
        $error("gpr_writeback: DEPTH must be a power of 2 and >= 2");
    end

    op_e                   op;
    entry_t                in_entry;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  accept;
    logic                  push;
    logic                  pop;

    entry_t                fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    assign op = op_e'(req_op);

    // Handshake and queue control. Ready is based on the registered count only.
    assign req_ready = reset && (fifo_count < CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_addr != '0) && (op != OP_RSVD);
    assign pop       = (fifo_count != '0);

    // Load alignment happens before the FIFO so the issue stage is a plain register copy.
    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sel_byte      = req_data[{req_offset, 3'b000} +: 8];
        sel_half      = req_offset[1] ? req_data[31:16] : req_data[15:0];
        in_entry.addr = req_addr;
        in_entry.data = req_data;
        in_entry.en   = 4'b1111;
        case (op)
            OP_LB:  in_entry.data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            OP_LBU: in_entry.data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            OP_LH:  in_entry.data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            OP_LHU: in_entry.data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
`ifdef GPR_WB_UNALIGNED_EN
            OP_LWL: begin
                in_entry.data = req_data << {2'd3 - req_offset, 3'b000};
                in_entry.en   = 4'b1111 << (2'd3 - req_offset);
            end
            OP_LWR: begin
                in_entry.data = req_data >> {req_offset, 3'b000};
                in_entry.en   = 4'b1111 >> req_offset;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: the FIFO storage is deliberately not reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            gpr_write     <= 1'b0;
            gpr_rd_addr   <= '0;
            gpr_rd_in     <= '0;
            gpr_byte_w_en <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                gpr_write     <= 1'b1;
                gpr_rd_addr   <= fifo_mem[rd_ptr].addr;
                gpr_rd_in     <= fifo_mem[rd_ptr].data;
                gpr_byte_w_en <= fifo_mem[rd_ptr].en;
            end else begin
                gpr_write <= 1'b0;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Hazard mask: occupied slots are those within fifo_count entries of the read pointer.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < fifo_count) begin
                pending_mask[fifo_mem[i].addr] = 1'b1;
            end
        end
        if (gpr_write) begin
            pending_mask[gpr_rd_addr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule
